// File: rtl/types_pkg.sv
// Shared types for the data-memory responder: access encodings, FSM states, helpers.
package types_pkg;

    localparam int unsigned XLEN = 32;

    // MSB distinguishes stores from loads so SB/SH/SW can share funct3 codes with LB/LH/LW.
    typedef enum logic [3:0] {
        MemLb  = 4'b0000,
        MemLh  = 4'b0001,
        MemLw  = 4'b0010,
        MemLbu = 4'b0100,
        MemLhu = 4'b0101,
        MemSb  = 4'b1000,
        MemSh  = 4'b1001,
        MemSw  = 4'b1010
    } mem_funct3_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } mem_state_t;

    // size = funct3[1:0]; undefined sizes fall back to word.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select with sign/zero extension; undefined funct3 codes behave as LW.
module load_extend
    import types_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
        case (mem_funct3_t'({1'b0, funct3_i}))
            MemLb:   result_o = {{24{byte_sel[7]}}, byte_sel};
            MemLh:   result_o = {{16{half_sel[15]}}, half_sel};
            MemLbu:  result_o = {24'h0, byte_sel};
            MemLhu:  result_o = {16'h0, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store interface.
// Optional MEM_PERF_EN adds saturating load/store/stall counters.
module data_mem_responder
    import types_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ReqValidM,
    input  logic            ReqWriteM,
    input  logic [31:0]     AddrM,
    input  logic [31:0]     WriteDataM,
    input  logic [2:0]      Funct3M,
    output logic            ReqReadyM,
    output logic            RespValidM,
    output logic [31:0]     ReadDataM,
    output logic            MisalignErrM,
    output logic            MemStall
`ifdef MEM_PERF_EN
    ,
    output logic [31:0]     LoadCount,
    output logic [31:0]     StoreCount,
    output logic [31:0]     StallCycles
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] CntInit = 4'(LATENCY - 1);

    logic [XLEN-1:0] mem_q [DEPTH];

    mem_state_t      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic            write_q, write_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            mis_q, mis_d;

    logic [AW-1:0]   idx;
    logic            misaligned;
    logic            access;
    logic [XLEN-1:0] load_word;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;
    logic            unused_addr;

    // Upper address bits wrap modulo DEPTH.
    assign unused_addr = ^AddrM[31:AW+2];

    assign idx        = addr_q[AW+1:2];
    assign misaligned = is_misaligned(f3_q[1:0], addr_q[1:0]);
    assign access     = (state_q == StBusy) && (cnt_q == 4'd0);

    load_extend u_load_extend (
        .word_i    (mem_q[idx]),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .result_o  (load_word)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        mis_d     = mis_q;
        ReqReadyM = 1'b0;
        MemStall  = 1'b0;
        case (state_q)
            StIdle: begin
                ReqReadyM = 1'b1;
                MemStall  = ReqValidM;
                if (ReqValidM) begin
                    addr_d  = AddrM[AW+1:0];
                    wdata_d = WriteDataM;
                    f3_d    = Funct3M;
                    write_d = ReqWriteM;
                    cnt_d   = CntInit;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                MemStall = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                    mis_d   = misaligned;
                    rdata_d = (write_q || misaligned) ? '0 : load_word;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign RespValidM   = (state_q == StResp);
    assign MisalignErrM = RespValidM & mis_q;
    assign ReadDataM    = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        case (f3_q[1:0])
            2'b00: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    // Store commits only on the BUSY->RESP edge; a reset that edge aborts it.
    always_ff @(posedge clk) begin
        if (!reset && access && write_q && !misaligned) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

`ifdef MEM_PERF_EN
    logic [31:0] load_cnt_q, store_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (RespValidM && !write_q && (load_cnt_q != '1)) begin
                load_cnt_q <= load_cnt_q + 32'd1;
            end
            if (RespValidM && write_q && (store_cnt_q != '1)) begin
                store_cnt_q <= store_cnt_q + 32'd1;
            end
            if (MemStall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign LoadCount   = load_cnt_q;
    assign StoreCount  = store_cnt_q;
    assign StallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table plus abort/alias sequences.
module tb_data_mem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqValidM;
    logic        ReqWriteM;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [2:0]  Funct3M;
    logic        ReqReadyM;
    logic        RespValidM;
    logic [31:0] ReadDataM;
    logic        MisalignErrM;
    logic        MemStall;
`ifdef MEM_PERF_EN
    logic [31:0] LoadCount;
    logic [31:0] StoreCount;
    logic [31:0] StallCycles;
`endif

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ReqValidM    (ReqValidM),
        .ReqWriteM    (ReqWriteM),
        .AddrM        (AddrM),
        .WriteDataM   (WriteDataM),
        .Funct3M      (Funct3M),
        .ReqReadyM    (ReqReadyM),
        .RespValidM   (RespValidM),
        .ReadDataM    (ReadDataM),
        .MisalignErrM (MisalignErrM),
        .MemStall     (MemStall)
`ifdef MEM_PERF_EN
        ,
        .LoadCount    (LoadCount),
        .StoreCount   (StoreCount),
        .StallCycles  (StallCycles)
`endif
    );

    typedef struct packed {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_mis;
    } vec_t;

    localparam int NumVec = 28;
    vec_t vecs [NumVec];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One request; samples on negedges, junk on the inputs after acceptance.
    task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, output logic rdy, output logic [31:0] rd,
                           output logic mis, output int lat, output int stall_n);
        @(negedge clk);
        ReqValidM  = 1'b1;
        ReqWriteM  = w;
        AddrM      = a;
        WriteDataM = d;
        Funct3M    = f3;
        #1;
        rdy     = ReqReadyM;
        stall_n = MemStall ? 1 : 0;
        rd      = '0;
        mis     = 1'b0;
        lat     = 0;
        @(posedge clk);
        #1;
        ReqValidM  = 1'b0;
        ReqWriteM  = ~w;
        AddrM      = 32'hFFFF_FFFF;
        WriteDataM = 32'h0;
        Funct3M    = 3'b111;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (MemStall) stall_n++;
            if (RespValidM) begin
                rd  = ReadDataM;
                mis = MisalignErrM;
                lat = n;
                break;
            end
        end
    endtask

    logic        rdy;
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          stall_n;
    logic        got_resp;

    initial begin
        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 32'h0000_0101, 32'h0000_0080, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,         32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{1'b0, 3'b100, 32'h0000_0101, 32'h0,         32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_80EF, 1'b0};
        vecs[6]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'hFFFF_DEAD, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'h0000_DEAD, 1'b0};
        vecs[8]  = '{1'b1, 3'b010, 32'h0000_0102, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_80EF, 1'b0};
        vecs[10] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'h0000_0000, 1'b1};
        vecs[11] = '{1'b1, 3'b010, 32'h0000_0104, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b1, 3'b001, 32'h0000_0106, 32'hABCD_1234, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'h1234_0000, 1'b0};
        vecs[14] = '{1'b0, 3'b001, 32'h0000_0106, 32'h0,         32'h0000_1234, 1'b0};
        vecs[15] = '{1'b0, 3'b000, 32'h0000_0107, 32'h0,         32'h0000_0012, 1'b0};
        vecs[16] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'hDEAD_80EF, 1'b0};
        vecs[17] = '{1'b0, 3'b111, 32'h0000_0104, 32'h0,         32'h1234_0000, 1'b0};
        vecs[18] = '{1'b0, 3'b010, 32'h0000_1100, 32'h0,         32'hDEAD_80EF, 1'b0};
        vecs[19] = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'hFFFF_FFDE, 1'b0};
        vecs[20] = '{1'b1, 3'b000, 32'h0000_1104, 32'h0000_0055, 32'h0000_0000, 1'b0};
        vecs[21] = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,         32'h1234_0055, 1'b0};
        vecs[22] = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h0000_80EF, 1'b0};
        vecs[23] = '{1'b0, 3'b010, 32'h0000_0103, 32'h0,         32'h0000_0000, 1'b1};
        vecs[24] = '{1'b1, 3'b001, 32'h0000_0103, 32'h0000_7777, 32'h0000_0000, 1'b1};
        vecs[25] = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hDEAD_80EF, 1'b0};
        vecs[26] = '{1'b1, 3'b010, 32'h0000_1100, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[27] = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 1'b0};

        reset      = 1'b1;
        ReqValidM  = 1'b0;
        ReqWriteM  = 1'b0;
        AddrM      = '0;
        WriteDataM = '0;
        Funct3M    = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("reset ReqReadyM", {31'b0, ReqReadyM}, 32'd1);
        check("reset RespValidM", {31'b0, RespValidM}, 32'd0);
        check("reset ReadDataM", ReadDataM, 32'd0);
        check("reset MisalignErrM", {31'b0, MisalignErrM}, 32'd0);
        check("reset MemStall", {31'b0, MemStall}, 32'd0);

`ifdef MEM_PERF_EN
        check("perf LoadCount reset", LoadCount, 32'd0);
        check("perf StoreCount reset", StoreCount, 32'd0);
        check("perf StallCycles reset", StallCycles, 32'd0);
        run_req(1'b1, 3'b010, 32'h200, 32'h0000_0001, rdy, rd, mis, lat, stall_n);
        run_req(1'b0, 3'b010, 32'h200, 32'h0, rdy, rd, mis, lat, stall_n);
        check("perf load data", rd, 32'h0000_0001);
        run_req(1'b0, 3'b010, 32'h200, 32'h0, rdy, rd, mis, lat, stall_n);
        @(negedge clk);
        check("perf LoadCount", LoadCount, 32'd2);
        check("perf StoreCount", StoreCount, 32'd1);
        check("perf StallCycles", StallCycles, 32'd9);
`endif

        for (int i = 0; i < NumVec; i++) begin
            run_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    rdy, rd, mis, lat, stall_n);
            check($sformatf("v%0d ready", i), {31'b0, rdy}, 32'd1);
            check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
            check($sformatf("v%0d misalign", i), {31'b0, mis}, {31'b0, vecs[i].exp_mis});
            check($sformatf("v%0d latency", i), lat, LATENCY + 1);
            check($sformatf("v%0d stall cycles", i), stall_n, LATENCY + 1);
        end

        // Reset while BUSY: store must be dropped and no response produced.
        @(negedge clk);
        ReqValidM  = 1'b1;
        ReqWriteM  = 1'b1;
        AddrM      = 32'h0000_0100;
        WriteDataM = 32'h1111_1111;
        Funct3M    = 3'b010;
        @(posedge clk);
        #1;
        ReqValidM = 1'b0;
        @(negedge clk);
        check("abort busy stall", {31'b0, MemStall}, 32'd1);
        check("abort busy ready", {31'b0, ReqReadyM}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        got_resp = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (RespValidM) got_resp = 1'b1;
        end
        check("abort no response", {31'b0, got_resp}, 32'd0);
        check("abort back to idle", {31'b0, ReqReadyM}, 32'd1);
        run_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, rdy, rd, mis, lat, stall_n);
        check("abort word unchanged", rd, 32'hCAFE_F00D);
        run_req(1'b0, 3'b010, DEPTH * 4 + 32'h100, 32'h0, rdy, rd, mis, lat, stall_n);
        check("alias word read", rd, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
